inst_mem_responder: RTL and testbench
=====================================

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 8: number of words in the memory array.
REQ-002 Parameter DATA_WIDTH, default 32: word width.
REQ-003 Parameter READ_LATENCY, default 2, legal range 1..15: cycles from request capture to data_valid.
REQ-004 Local ADDR_WIDTH SHALL equal $clog2(MEM_DEPTH).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 Addr  input  ADDR_WIDTH  word address from initiator.
REQ-008 Data  inout  DATA_WIDTH  read data driven by block; write data driven by initiator.
REQ-009 we  input  1  1 = write request, 0 = read request.
REQ-010 req_valid  input  1  request pending; held high by initiator until response consumed.
REQ-011 data_valid  output  1  response ready (read data on Data, or write acknowledge).
REQ-012 load_en  input  1  backdoor preload strobe.
REQ-013 load_addr  input  ADDR_WIDTH  preload address.
REQ-014 load_data  input  DATA_WIDTH  preload data.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, RESPOND.
REQ-017 IDLE: on an edge with req_valid=1, capture Addr, we and (if we=1) Data into holding registers; go to ACCESS with latency counter = READ_LATENCY-1.
REQ-018 ACCESS: counter decrements each edge; when counter=0 and req_valid=1, go to RESPOND.
REQ-019 data_valid SHALL rise on edge T+READ_LATENCY, where T is the capture edge; READ_LATENCY=1 gives RESPOND directly after one ACCESS edge.
REQ-020 On the ACCESS->RESPOND edge: read = register mem[captured Addr] into the read-data register; write = store captured data to mem[captured Addr].
REQ-021 RESPOND: data_valid=1; if captured we=0, Data is driven with the read-data register, otherwise Data is high-impedance.
REQ-022 Data SHALL be high-impedance in IDLE and ACCESS.
REQ-023 RESPOND SHALL persist while req_valid=1; on an edge with req_valid=0, go to IDLE and drop data_valid.
REQ-024 A new request requires req_valid sampled low at least one edge after RESPOND (no back-to-back capture without a low cycle).
REQ-025 Abort: req_valid=0 sampled in ACCESS returns to IDLE; no memory write; data_valid never asserts.
REQ-026 Addr/we/Data changes after capture SHALL be ignored until the next IDLE capture.
REQ-027 load_en=1 writes load_data to mem[load_addr] on that edge in any state.
REQ-028 Simultaneous load and response write to the same address: the load wins.
REQ-029 Simultaneous load and read capture into the read-data register from the same address: the read returns the old (pre-load) word.
REQ-030 Address arithmetic SHALL be unsigned ADDR_WIDTH with no wrap logic; the initiator guarantees Addr < MEM_DEPTH.

Reset
REQ-031 reset=1 on an edge SHALL force IDLE, data_valid=0, busy=0, counter=0, Data high-impedance, read-data register=0.
REQ-032 Reset mid-ACCESS or mid-RESPOND SHALL abandon the transaction with no memory write.
REQ-033 Memory array contents SHALL NOT be cleared by reset; load_en is ignored while reset=1.

Verification
REQ-034 Preload mem[3]=0xDEADBEEF; read Addr=3 at edge T (latency 2) -> data_valid=1 and Data=0xDEADBEEF from edge T+2 until req_valid drops; busy=1 throughout.
REQ-035 Write Addr=5, Data=0x12345678, then read Addr=5 -> data_valid ack with Data=Z during the write; read returns 0x12345678.
REQ-036 Fetch-style loop over Addr 0..7 with one low cycle between requests -> eight responses with preloaded values in order; no missed or duplicate data_valid.
REQ-037 Drop req_valid one edge after capture (latency 2) -> data_valid stays 0, FSM returns to IDLE; a later read of the same address returns unchanged contents.
REQ-038 Assert reset in RESPOND -> next edge data_valid=0, busy=0, Data=Z; memory contents are preserved (verified by a read).
REQ-039 Load mem[2]=0xA5A5A5A5 on the same edge as the response write of 0x11111111 to Addr=2 -> mem[2]=0xA5A5A5A5.

Source files
------------

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: request/response FSM in front of a small word
// memory with a configurable read latency and a backdoor preload port.
module inst_mem_responder #(
    parameter int MEM_DEPTH    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Addr,
    inout  wire  [DATA_WIDTH-1:0] Data,
    input  logic                  we,
    input  logic                  req_valid,
    output logic                  data_valid,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_reg;
    logic [3:0]            counter_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  we_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  data_valid_reg;
    logic                  busy_reg;
    logic                  drive_reg;
    logic                  resp_edge;

    // The edge on which the transaction commits: memory is read or written here.
    assign resp_edge = (state_reg == ACCESS) && (counter_reg == 4'd0) && req_valid && !reset;

    // Load is written last so it overrides a same-address response write.
    always_ff @(posedge clk) begin
        if (resp_edge && we_reg) begin
            mem[addr_reg] <= wdata_reg;
        end
        if (load_en && !reset) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            counter_reg    <= 4'd0;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            data_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            drive_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg    <= Addr;
                        we_reg      <= we;
                        if (we) begin
                            wdata_reg <= Data;
                        end
                        counter_reg <= LAT_INIT;
                        busy_reg    <= 1'b1;
                        state_reg   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!req_valid) begin
                        counter_reg <= 4'd0;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else if (counter_reg == 4'd0) begin
                        // Nonblocking read returns the pre-load word on a same-edge load.
                        if (!we_reg) begin
                            rdata_reg <= mem[addr_reg];
                        end
                        drive_reg      <= !we_reg;
                        data_valid_reg <= 1'b1;
                        state_reg      <= RESPOND;
                    end else begin
                        counter_reg <= counter_reg - 4'd1;
                    end
                end
                RESPOND: begin
                    if (!req_valid) begin
                        data_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        drive_reg      <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Data       = drive_reg ? rdata_reg : {DATA_WIDTH{1'bz}};
    assign data_valid = data_valid_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench for inst_mem_responder: a model memory predicts read data,
// responses are popped from a queue when data_valid appears.
module tb_inst_mem_responder;

    localparam int L  = 2;
    localparam int AW = 3;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Addr;
    logic          we;
    logic          req_valid;
    logic          data_valid;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          busy;
    logic          tb_drive;
    logic [DW-1:0] tb_data;
    wire  [DW-1:0] data_bus;

    // When the bench expects the DUT to float Data it drives a known value itself.
    assign data_bus = tb_drive ? tb_data : {DW{1'bz}};

    logic [DW-1:0] model [8];
    logic [DW-1:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_mem_responder #(.MEM_DEPTH(8), .DATA_WIDTH(DW), .READ_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .Data(data_bus), .we(we),
        .req_valid(req_valid), .data_valid(data_valid), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy)
    );

    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        model[a] = d;
    endtask

    // One full request/response; optional load to the same address on the commit edge.
    task automatic do_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                          input logic coll, input logic [DW-1:0] cd);
        logic [DW-1:0] exp;
        logic [DW-1:0] hold;
        @(negedge clk);
        Addr = a; we = w; req_valid = 1'b1;
        if (w) begin
            tb_drive = 1'b1; tb_data = wd;
        end else begin
            tb_drive = 1'b0;
            exp_q.push_back(model[a]);
        end
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL busy_in_txn addr=%0d k=%0d got=%b want=1", a, k, busy);
            end
            checks++;
            if (data_valid !== (k == L + 1)) begin
                errors++;
                $display("FAIL dv_timing addr=%0d k=%0d got=%b want=%b", a, k, data_valid, (k == L + 1));
            end
            if (k == 1) begin
                Addr = a ^ 3'd1; we = ~w;
                if (w) tb_data = ~wd;
            end
            if (coll && k == L) begin
                load_en = 1'b1; load_addr = a; load_data = cd;
            end
            if (k == L + 1) load_en = 1'b0;
        end
        checks++;
        if (w) begin
            if (data_bus !== tb_data) begin
                errors++; $display("FAIL write_ack_z addr=%0d got=%h want=%h", a, data_bus, tb_data);
            end
        end else if (exp_q.size() == 0) begin
            errors++; $display("FAIL scoreboard_empty addr=%0d got=%h want=none", a, data_bus);
        end else begin
            exp = exp_q.pop_front();
            if (data_bus !== exp) begin
                errors++; $display("FAIL read_data addr=%0d got=%h want=%h", a, data_bus, exp);
            end
        end
        hold = data_bus;
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data_bus !== hold) begin
            errors++;
            $display("FAIL respond_hold addr=%0d dv=%b data=%h want dv=1 data=%h", a, data_valid, data_bus, hold);
        end
        req_valid = 1'b0; tb_drive = 1'b1; tb_data = '0;
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0 || data_bus !== '0) begin
            errors++;
            $display("FAIL release addr=%0d dv=%b busy=%b data=%h want dv=0 busy=0 data=0",
                     a, data_valid, busy, data_bus);
        end
        if (w) model[a] = wd;
        if (coll) model[a] = cd;
        $display("txn addr=%0d we=%0d data=%h", a, w, hold);
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b1; Addr = '0; we = 1'b0;
        tb_drive = 1'b1; tb_data = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0 || data_bus !== '0) begin
            errors++;
            $display("FAIL reset_state dv=%b busy=%b data=%h want dv=0 busy=0 data=0", data_valid, busy, data_bus);
        end
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_preload;
        for (int i = 0; i < 8; i++) load_word(3'(i), 32'h1000_0000 + 32'(i) * 32'h0101);
        load_word(3'd3, 32'hDEAD_BEEF);
    endtask

    task automatic test_load_in_reset;
        @(negedge clk);
        reset = 1'b1; load_en = 1'b1; load_addr = 3'd6; load_data = 32'hBAD0_BAD0;
        @(negedge clk);
        reset = 1'b0; load_en = 1'b0;
        do_txn(3'd6, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_read;
        do_txn(3'd3, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_write;
        do_txn(3'd5, 1'b1, 32'h1234_5678, 1'b0, '0);
        do_txn(3'd5, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_fetch_loop;
        for (int i = 0; i < 8; i++) do_txn(3'(i), 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_abort;
        @(negedge clk);
        Addr = 3'd4; we = 1'b1; tb_drive = 1'b1; tb_data = 32'hCAFE_0004; req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || data_valid !== 1'b0) begin
            errors++; $display("FAIL abort_access busy=%b dv=%b want busy=1 dv=0", busy, data_valid);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (data_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL abort_idle k=%0d dv=%b busy=%b want dv=0 busy=0", k, data_valid, busy);
            end
        end
        do_txn(3'd4, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        Addr = 3'd1; we = 1'b0; tb_drive = 1'b0; req_valid = 1'b1;
        repeat (L + 1) @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data_bus !== model[1]) begin
            errors++;
            $display("FAIL pre_reset_respond dv=%b data=%h want dv=1 data=%h", data_valid, data_bus, model[1]);
        end
        reset = 1'b1; tb_drive = 1'b1; tb_data = '0;
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0 || data_bus !== '0) begin
            errors++;
            $display("FAIL reset_in_respond dv=%b busy=%b data=%h want dv=0 busy=0 data=0",
                     data_valid, busy, data_bus);
        end
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        Addr = 3'd7; we = 1'b1; tb_data = 32'h7777_7777; req_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            errors++; $display("FAIL reset_in_access busy=%b dv=%b want busy=0 dv=0", busy, data_valid);
        end
        do_txn(3'd1, 1'b0, '0, 1'b0, '0);
        do_txn(3'd7, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_collisions;
        do_txn(3'd2, 1'b1, 32'h1111_1111, 1'b1, 32'hA5A5_A5A5);
        do_txn(3'd2, 1'b0, '0, 1'b0, '0);
        do_txn(3'd6, 1'b0, '0, 1'b1, 32'h6666_0006);
        do_txn(3'd6, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        test_reset;
        test_preload;
        test_load_in_reset;
        test_read;
        test_write;
        test_fetch_loop;
        test_abort;
        test_reset_mid;
        test_collisions;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
